// File: rtl/axi4_decoder_cfg_sequencer_if.sv
// Entry stream from the boot/host agent into the decoder config sequencer.
// One (slave, permission-mask) entry per valid/ready transfer.
interface axi4_decoder_cfg_sequencer_if #(
   parameter int NUM_SLAVES  = 3,
   parameter int NUM_MASTERS = 2
);
   localparam int SW = $clog2(NUM_SLAVES) + 1;

   logic                   req_valid;
   logic                   req_ready;
   logic [SW-1:0]          req_slave_id;
   logic [NUM_MASTERS-1:0] req_perm;
   logic                   req_last;

   modport master (
      output req_valid,
      output req_slave_id,
      output req_perm,
      output req_last,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_slave_id,
      input  req_perm,
      input  req_last,
      output req_ready
   );
endinterface

// File: rtl/axi4_decoder_cfg_sequencer.sv
// Programs the secure AXI4 decoder permission matrix with the
// unlock / settle / write / relock ordering, optionally production-locking it.
module axi4_decoder_cfg_sequencer #(
   parameter int NUM_SLAVES     = 3,
   parameter int NUM_MASTERS    = 2,
   parameter int SETTLE_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 256,
   localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   cfg_start,
   input  logic                   cfg_commit,
   axi4_decoder_cfg_sequencer_if.slave req,
   output logic                   config_mode,
   output logic                   config_valid,
   output logic [IW-1:0]          config_slave_id,
   output logic [NUM_MASTERS-1:0] config_permissions,
   output logic                   production_mode,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic [1:0]             err_code,
   output logic [7:0]             write_count
);

   localparam int SW  = $clog2(NUM_SLAVES) + 1;
   localparam int STW = $clog2(SETTLE_CYCLES + 1);
   localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_UNLOCK,
      S_WRITE,
      S_DRAIN,
      S_COMMIT,
      S_RELOCK,
      S_PLOCKED
   } state_t;

   state_t         state;
   logic [STW-1:0] settle_cnt;
   logic [TW-1:0]  idle_cnt;
   logic           commit_q;
   logic           req_ready;
   logic           slave_ok;

   assign req.req_ready = req_ready;
   assign slave_ok = req.req_slave_id < SW'(NUM_SLAVES);

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state              <= S_IDLE;
         settle_cnt         <= '0;
         idle_cnt           <= '0;
         commit_q           <= 1'b0;
         req_ready          <= 1'b0;
         config_mode        <= 1'b0;
         config_valid       <= 1'b0;
         config_slave_id    <= '0;
         config_permissions <= '0;
         production_mode    <= 1'b0;
         busy               <= 1'b0;
         done               <= 1'b0;
         error              <= 1'b0;
         err_code           <= 2'd0;
         write_count        <= 8'd0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (cfg_start) begin
                  commit_q    <= cfg_commit;
                  write_count <= 8'd0;
                  err_code    <= 2'd0;
                  busy        <= 1'b1;
                  config_mode <= 1'b1;
                  settle_cnt  <= '0;
                  state       <= S_UNLOCK;
               end
            end
            S_UNLOCK: begin
               if (settle_cnt == STW'(SETTLE_CYCLES - 1)) begin
                  req_ready <= 1'b1;
                  idle_cnt  <= '0;
                  state     <= S_WRITE;
               end else begin
                  settle_cnt <= settle_cnt + STW'(1);
               end
            end
            S_WRITE: begin
               config_valid <= 1'b0;
               if (req.req_valid && req_ready) begin
                  idle_cnt <= '0;
                  if (slave_ok) begin
                     config_valid       <= 1'b1;
                     config_slave_id    <= req.req_slave_id[IW-1:0];
                     config_permissions <= req.req_perm;
                     if (write_count != 8'hFF)
                        write_count <= write_count + 8'd1;
                     if (req.req_last) begin
                        req_ready <= 1'b0;
                        state     <= S_DRAIN;
                     end
                  end else begin
                     err_code    <= 2'd1;
                     error       <= 1'b1;
                     busy        <= 1'b0;
                     config_mode <= 1'b0;
                     req_ready   <= 1'b0;
                     state       <= S_RELOCK;
                  end
               end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  err_code    <= 2'd2;
                  error       <= 1'b1;
                  busy        <= 1'b0;
                  config_mode <= 1'b0;
                  req_ready   <= 1'b0;
                  state       <= S_RELOCK;
               end else begin
                  idle_cnt <= idle_cnt + TW'(1);
               end
            end
            S_DRAIN: begin
               config_valid <= 1'b0;
               if (commit_q) begin
                  production_mode <= 1'b1;
                  state           <= S_COMMIT;
               end else begin
                  config_mode <= 1'b0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  state       <= S_RELOCK;
               end
            end
            S_COMMIT: begin
               config_mode <= 1'b0;
               busy        <= 1'b0;
               done        <= 1'b1;
               state       <= S_PLOCKED;
            end
            // Relock outputs were already driven on entry; just retire.
            S_RELOCK: state <= S_IDLE;
            S_PLOCKED: begin
               if (cfg_start) begin
                  error    <= 1'b1;
                  err_code <= 2'd3;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_decoder_cfg_sequencer.sv
// Self-checking bench for axi4_decoder_cfg_sequencer: directed sessions plus
// randomized entry streams checked against session-level expectations.
module tb_axi4_decoder_cfg_sequencer;
   localparam int NS  = 3;
   localparam int NM  = 2;
   localparam int SET = 2;
   localparam int TO  = 8;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          cfg_start = 1'b0;
   logic          cfg_commit = 1'b0;
   logic          config_mode, config_valid;
   logic [1:0]    config_slave_id;
   logic [NM-1:0] config_permissions;
   logic          production_mode, busy, done, error;
   logic [1:0]    err_code;
   logic [7:0]    write_count;

   int checks = 0;
   int errors = 0;
   int age = 0;
   int ent_id[300];
   int ent_perm[300];

   axi4_decoder_cfg_sequencer_if #(.NUM_SLAVES(NS), .NUM_MASTERS(NM)) rq();

   axi4_decoder_cfg_sequencer #(
      .NUM_SLAVES(NS), .NUM_MASTERS(NM),
      .SETTLE_CYCLES(SET), .TIMEOUT_CYCLES(TO)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .cfg_start(cfg_start), .cfg_commit(cfg_commit),
      .req(rq),
      .config_mode(config_mode), .config_valid(config_valid),
      .config_slave_id(config_slave_id),
      .config_permissions(config_permissions),
      .production_mode(production_mode), .busy(busy),
      .done(done), .error(error), .err_code(err_code),
      .write_count(write_count)
   );

   always #5 aclk = ~aclk;

   task automatic cyc();
      @(negedge aclk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // A write must only appear inside an unlocked window that has settled.
   always @(negedge aclk) begin
      if (config_mode === 1'b1) age = age + 1;
      else age = 0;
      if (config_valid === 1'b1)
         chk("cv_guard", {31'd0, (config_mode === 1'b1) && (age > SET)}, 1);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic start_session(input bit commit);
      int cnt;
      cfg_start = 1'b1;
      cfg_commit = commit;
      cyc();
      cfg_start = 1'b0;
      cfg_commit = 1'b0;
      chk("start", {config_mode, busy, rq.req_ready, err_code, write_count},
          {3'b110, 10'd0});
      cnt = 1;
      while (rq.req_ready !== 1'b1 && cnt < 20) begin
         cyc();
         cnt++;
      end
      chk("ready_lat", cnt, 1 + SET);
   endtask

   task automatic run_session(input int n, input bit commit, input int gap_max);
      int good;
      int g;
      good = 0;
      for (int i = 0; i < n; i++) begin
         rq.req_valid = 1'b1;
         rq.req_slave_id = 3'(ent_id[i]);
         rq.req_perm = 2'(ent_perm[i]);
         rq.req_last = (i == n - 1);
         cyc();
         rq.req_valid = 1'b0;
         rq.req_last = 1'b0;
         if (ent_id[i] >= NS) begin
            chk("bad_abort",
                {error, err_code, config_valid, config_mode, busy, production_mode},
                {1'b1, 2'd1, 4'b0000});
            chk("bad_count", write_count, good);
            cyc();
            chk("bad_after", {error, err_code, production_mode, config_mode},
                {1'b0, 2'd1, 2'b00});
            return;
         end
         good++;
         chk("cv", {config_valid, config_slave_id, config_permissions},
             {1'b1, 2'(ent_id[i]), 2'(ent_perm[i])});
         chk("wcount", write_count, (good > 255) ? 255 : good);
         if (i < n - 1) begin
            g = $urandom_range(0, gap_max);
            repeat (g) begin
               cyc();
               chk("gap", {config_valid, rq.req_ready}, 2'b01);
            end
         end
      end
      chk("drain", {rq.req_ready, config_mode, busy, done}, 4'b0110);
      cyc();
      if (commit) begin
         chk("commit", {production_mode, config_mode, config_valid, done, busy},
             5'b11001);
         cyc();
         chk("commit_done", {done, config_mode, busy, production_mode}, 4'b1001);
      end else begin
         chk("relock",
             {done, error, config_mode, config_valid, busy, production_mode},
             6'b100000);
      end
      chk("end_count", write_count, (good > 255) ? 255 : good);
      chk("end_err", err_code, 0);
      cyc();
      chk("pulse_end", {done, error}, 0);
   endtask

   initial begin
      int cnt;
      int n;
      int b;
      bit bad;
      bit cm;
      rq.req_valid = 1'b0;
      rq.req_slave_id = '0;
      rq.req_perm = '0;
      rq.req_last = 1'b0;

      // reset wins over a simultaneous start
      aresetn = 1'b0;
      cfg_start = 1'b1;
      repeat (3) cyc();
      chk("rst_outs",
          {config_mode, config_valid, config_slave_id, config_permissions,
           production_mode, busy, done, error, err_code, write_count,
           rq.req_ready}, 0);
      aresetn = 1'b1;
      cfg_start = 1'b0;
      cyc();
      chk("rst_idle", {busy, config_mode}, 0);

      // three back-to-back entries, no commit
      ent_id[0] = 0; ent_perm[0] = 1;
      ent_id[1] = 1; ent_perm[1] = 2;
      ent_id[2] = 2; ent_perm[2] = 3;
      start_session(1'b0);
      run_session(3, 1'b0, 0);

      // bad slave id aborts even with commit requested
      ent_id[0] = 0; ent_perm[0] = 1;
      ent_id[1] = 3; ent_perm[1] = 2;
      start_session(1'b1);
      run_session(2, 1'b1, 0);
      cyc();
      chk("bad_hold", {err_code, production_mode, error}, {2'd1, 2'b00});

      // timeout with no entries
      start_session(1'b0);
      cnt = 0;
      while (rq.req_ready === 1'b1 && error !== 1'b1 && cnt < 50) begin
         cnt++;
         cyc();
      end
      chk("to_cycles", cnt, TO);
      chk("to_abort", {error, err_code, write_count, config_mode, busy},
          {1'b1, 2'd2, 10'd0});
      cyc();
      chk("to_pulse", {error, err_code}, 3'b010);

      // randomized sessions, some with an injected bad id
      for (int s = 0; s < 8; s++) begin
         n = $urandom_range(1, 5);
         for (int i = 0; i < n; i++) begin
            ent_id[i] = $urandom_range(0, NS - 1);
            ent_perm[i] = $urandom_range(0, 3);
         end
         bad = ($urandom_range(0, 2) == 0);
         if (bad) begin
            b = $urandom_range(0, n - 1);
            ent_id[b] = $urandom_range(NS, 7);
            n = b + 1;
         end
         cm = bad ? 1'($urandom_range(0, 1)) : 1'b0;
         start_session(cm);
         run_session(n, cm, 2);
      end

      // long session saturates write_count
      for (int i = 0; i < 260; i++) begin
         ent_id[i] = $urandom_range(0, NS - 1);
         ent_perm[i] = $urandom_range(0, 3);
      end
      start_session(1'b0);
      run_session(260, 1'b0, 0);

      // reset in the middle of WRITE
      start_session(1'b0);
      rq.req_valid = 1'b1;
      rq.req_slave_id = 3'd1;
      rq.req_perm = 2'b11;
      rq.req_last = 1'b0;
      cyc();
      rq.req_valid = 1'b0;
      chk("mid_cv", {config_valid, write_count}, {1'b1, 8'd1});
      aresetn = 1'b0;
      cyc();
      chk("mid_rst",
          {config_mode, config_valid, busy, write_count, rq.req_ready}, 0);
      aresetn = 1'b1;
      cyc();
      chk("mid_idle", {busy, config_mode}, 0);

      // commit session then production lock
      ent_id[0] = 1; ent_perm[0] = 3;
      start_session(1'b1);
      run_session(1, 1'b1, 0);
      chk("plocked", {production_mode, config_mode, rq.req_ready, busy}, 4'b1000);
      cfg_start = 1'b1;
      cyc();
      cfg_start = 1'b0;
      chk("plk_err", {error, err_code, config_mode, busy, production_mode},
          {1'b1, 2'd3, 2'b00, 1'b1});
      cyc();
      chk("plk_hold", {error, err_code, config_mode}, {1'b0, 2'd3, 1'b0});

      aresetn = 1'b0;
      cyc();
      chk("final_rst", production_mode, 0);
      aresetn = 1'b1;
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/axi4_decoder_cfg_sequencer.md
# axi4_decoder_cfg_sequencer

Sequencer that programs the permission matrix of the secure AXI4 address decoder.
- Accepts a stream of (slave, master-permission-mask) entries from a boot/host agent over a valid/ready handshake.
- Drives the decoder's config_mode / config_valid / config_slave_id / config_permissions / production_mode pins with the unlock-settle-write-relock ordering the decoder's config FSM requires.
- Optionally commits the decoder to its permanent production lock.
- Sits beside the decoder in the interconnect's security subsystem; its outputs connect 1:1 to the decoder's configuration inputs.

## Interface
Parameters:
- NUM_SLAVES, 3: decoder slave count; legal req_slave_id range is 0..NUM_SLAVES-1.
- NUM_MASTERS, 2: width of a permission mask.
- SETTLE_CYCLES, 2: cycles config_mode is held high before the first config_valid. Minimum 2.
- TIMEOUT_CYCLES, 256: idle cycles in WRITE, with no req_valid, before abort.

Ports:
- aclk, in, 1: single clock; all logic on rising edge.
- aresetn, in, 1: synchronous, active-low reset.
- cfg_start, in, 1: single-cycle request to begin a programming session.
- cfg_commit, in, 1: sampled with cfg_start; 1 = enter production lock after the last entry.
- req_valid, in, 1: entry valid.
- req_ready, out, 1: sequencer can accept an entry.
- req_slave_id, in, $clog2(NUM_SLAVES)+1: target slave. The extra bit allows out-of-range detection.
- req_perm, in, NUM_MASTERS: permission mask for that slave.
- req_last, in, 1: final entry of the session.
- config_mode, out, 1: to decoder.
- config_valid, out, 1: to decoder.
- config_slave_id, out, $clog2(NUM_SLAVES): to decoder.
- config_permissions, out, NUM_MASTERS: to decoder.
- production_mode, out, 1: to decoder. Sticky until reset.
- busy, out, 1: session in progress.
- done, out, 1: one-cycle pulse on successful completion.
- error, out, 1: one-cycle pulse on abort or rejected start.
- err_code, out, 2: 1 = bad slave id, 2 = timeout, 3 = start after production lock. Held until the next cfg_start.
- write_count, out, 8: entries written in the current or last session. Saturates at 255.

## Operation
- All outputs are registered and reset to 0 while aresetn=0. The FSM resets to IDLE.
- States: IDLE, UNLOCK, WRITE, DRAIN, COMMIT, RELOCK, PLOCKED.
- IDLE
  - cfg_start=1: latch cfg_commit; clear write_count and err_code; busy=1; config_mode=1; go to UNLOCK.
  - cfg_start while busy is ignored.
- UNLOCK: hold config_mode=1 for SETTLE_CYCLES cycles (internal counter), then go to WRITE.
- WRITE: req_ready=1. On req_valid&&req_ready:
  - If req_slave_id < NUM_SLAVES: next cycle config_valid=1, config_slave_id and config_permissions take the request values, write_count increments.
  - Otherwise: no config_valid; err_code=1; go to RELOCK with the abort flag set.
  - If req_last is set on a valid entry: go to DRAIN.
  - Back-to-back entries are allowed at one per cycle.
  - The idle counter resets on each accepted entry. When it reaches TIMEOUT_CYCLES: err_code=2; abort to RELOCK.
- DRAIN: one cycle. config_mode stays 1 and the final config_valid is presented. req_ready=0.
  - cfg_commit latched: go to COMMIT.
  - Otherwise: go to RELOCK.
- COMMIT: one cycle with config_mode=1 and production_mode=1. Then config_mode=0, done pulse, busy=0, go to PLOCKED.
- RELOCK: config_mode=0, config_valid=0, busy=0. Pulse error if the abort flag is set, else pulse done. Go to IDLE.
- PLOCKED
  - Terminal until reset.
  - production_mode=1, config_mode=0, req_ready=0.
  - cfg_start: error pulse with err_code=3 the next cycle.
- config_valid is never high while config_mode is low. It is never high within the first SETTLE_CYCLES cycles after config_mode rises.
- An abort never asserts production_mode.
- Reset mid-session: all outputs return to 0 synchronously. The decoder's own reset separately restores its deny-all state.

## Timing
- cfg_start sampled at edge 0: config_mode=1 from cycle 1. req_ready=1 from cycle 1+SETTLE_CYCLES.
- Entry accepted at edge k: config_valid=1 during cycle k+1 only, unless the next entry was accepted at edge k+1.
- req_last accepted at edge k:
  - cycle k+1 is DRAIN;
  - with commit: COMMIT in cycle k+2, config_mode=0 from k+3, done in k+3;
  - without commit: RELOCK in cycle k+2, done in k+2, config_mode=0 from k+2.
- Error and done pulses last exactly one cycle. busy falls in the same cycle as the pulse.
- Simultaneous cfg_start with aresetn=0: reset wins.

## Test plan
- Reset: hold aresetn=0 for 3 cycles with cfg_start=1 -> all outputs 0, state IDLE.
- Normal session (SETTLE_CYCLES=2, no commit): 3 back-to-back entries (0,'b01), (1,'b10), (2,'b11 last):
  - config_valid high 3 consecutive cycles with matching id/perm;
  - first config_valid ≥2 cycles after config_mode rises;
  - write_count=3; done pulse; config_mode low; production_mode=0.
- Commit session with one entry (1,'b11,last):
  - production_mode=1 for one cycle with config_mode=1, then config_mode=0;
  - done pulse; state PLOCKED;
  - a later cfg_start -> error pulse, err_code=3, no config_mode.
- Bad id: entry with req_slave_id=3 (NUM_SLAVES=3) -> no config_valid, error pulse, err_code=1, config_mode=0, production_mode=0 even with cfg_commit=1.
- Timeout (TIMEOUT_CYCLES=8): start, send no entries -> error at the 8th idle WRITE cycle, err_code=2, write_count=0.
- Reset mid-WRITE after 1 entry -> next cycle config_mode=0, config_valid=0, busy=0, write_count=0.
